// File: rtl/rv_structs.sv
// Shared types for the rv_alu2 execute stage: ALU opcodes, the ALU control
// word, writeback source select, funct3 codes and the branch comparator.
package rv_structs;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLT  = 4'd5,
    ALU_SLTU = 4'd6,
    ALU_SLL  = 4'd7,
    ALU_SRL  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_e;

  typedef struct packed {
    logic    div;
    alu_op_e op;
  } alu_ctrl_t;

  typedef enum logic [1:0] {
    RES_ALU     = 2'd0,
    RES_MEM     = 2'd1,
    RES_PC_NEXT = 2'd2
  } res_src_t;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  // Branch condition; unused funct3 codes never take the branch.
  function automatic logic branch_cond(input logic [2:0] funct3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
    logic res;
    case (funct3)
      F3_BEQ:  res = (a == b);
      F3_BNE:  res = (a != b);
      F3_BLT:  res = ($signed(a) < $signed(b));
      F3_BGE:  res = ($signed(a) >= $signed(b));
      F3_BLTU: res = (a < b);
      F3_BGEU: res = (a >= b);
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/rv_div.sv
// Iterative restoring divider: 32 iterations on operand magnitudes, sign
// correction applied combinationally on the outputs while in DONE.
//
// state  | meaning
// IDLE   | waiting for start; operands captured on start
// RUN    | one quotient bit per cycle, counter 31 down to 0
// DONE   | quotient/remainder valid; held while i_hold is high
module rv_div
  import rv_structs::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_abort,
  input  logic        i_start,
  input  logic        i_hold,
  input  logic        i_signed,
  input  logic [31:0] i_dividend,
  input  logic [31:0] i_divisor,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_quotient,
  output logic [31:0] o_remainder
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]  state;
  logic [4:0]  cnt;
  logic [31:0] quo, rem, dvs;
  logic        neg_q, neg_r, dvz;

  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] rem_shift, trial;
  logic        accept;

  assign a_neg = i_signed & i_dividend[31];
  assign b_neg = i_signed & i_divisor[31];
  assign a_mag = a_neg ? (32'd0 - i_dividend) : i_dividend;
  assign b_mag = b_neg ? (32'd0 - i_divisor) : i_divisor;

  // One restoring step: shift in the next dividend bit, keep the subtraction if it does not borrow.
  assign rem_shift = {rem, quo[31]};
  assign trial     = rem_shift - {1'b0, dvs};
  assign accept    = ~trial[32];

  // FSM, iteration counter and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      quo   <= '0;
      rem   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      dvz   <= 1'b0;
    end else if (i_abort) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (i_start) begin
          state <= S_RUN;
          cnt   <= 5'd31;
          quo   <= a_mag;
          rem   <= '0;
          dvs   <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          dvz   <= (i_divisor == 32'd0);
        end
        S_RUN: begin
          quo <= {quo[30:0], accept};
          rem <= accept ? trial[31:0] : rem_shift[31:0];
          if (cnt == 5'd0) state <= S_DONE;
          else             cnt   <= cnt - 5'd1;
        end
        S_DONE: if (!i_hold) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = (state == S_RUN);
  assign o_done      = (state == S_DONE);
  // Divide by zero yields all ones regardless of sign; the remainder falls out as the dividend.
  assign o_quotient  = dvz ? 32'hFFFF_FFFF : (neg_q ? (32'd0 - quo) : quo);
  assign o_remainder = neg_r ? (32'd0 - rem) : rem;

endmodule

// File: rtl/rv_alu2.sv
// Execute stage: ALU, branch decision and PC redirect, all registered for the
// memory stage. Build with RV_ALU2_DIV_EN defined to include the iterative
// divider; without it a divide op retires in one cycle as an illegal
// instruction trap and o_stall_req is tied low.
module rv_alu2
  import rv_structs::*;
#(
  parameter int IADDR_SPACE_BITS = 16
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic                        i_flush,
  input  logic                        i_stall,
  input  logic [31:0]                 i_op1,
  input  logic [31:0]                 i_op2,
  input  logic [31:0]                 i_store_data,
  input  logic [2:0]                  i_funct3,
  input  alu_ctrl_t                   i_alu_ctrl,
  input  logic [4:0]                  i_rd,
  input  logic                        i_reg_write,
  input  logic                        i_store,
  input  logic                        i_inst_jal_jalr,
  input  logic                        i_inst_branch,
  input  logic                        i_to_trap,
  input  res_src_t                    i_res_src,
  input  logic [IADDR_SPACE_BITS-1:1] i_pc_next,
  input  logic [IADDR_SPACE_BITS-1:1] i_pc_target,
  output logic                        o_stall_req,
  output logic                        o_pc_select,
  output logic [IADDR_SPACE_BITS-1:1] o_pc_target,
  output logic [31:0]                 o_result,
  output logic [31:0]                 o_store_data,
  output logic [4:0]                  o_rd,
  output logic                        o_reg_write,
  output logic                        o_store,
  output res_src_t                    o_res_src,
  output logic [2:0]                  o_funct3,
  output logic [IADDR_SPACE_BITS-1:1] o_pc_next,
  output logic                        o_to_trap
);

  logic [31:0] alu_res;
  logic [31:0] result_d;
  logic        reg_write_d;
  logic        to_trap_d;
  logic        pc_select_d;
  logic        load;
  logic [4:0]  shamt;

  assign shamt = i_op2[4:0];

  // Single-cycle ALU operations.
  always_comb begin
    alu_res = '0;
    case (i_alu_ctrl.op)
      ALU_ADD:  alu_res = i_op1 + i_op2;
      ALU_SUB:  alu_res = i_op1 - i_op2;
      ALU_AND:  alu_res = i_op1 & i_op2;
      ALU_OR:   alu_res = i_op1 | i_op2;
      ALU_XOR:  alu_res = i_op1 ^ i_op2;
      ALU_SLT:  alu_res = {31'b0, $signed(i_op1) < $signed(i_op2)};
      ALU_SLTU: alu_res = {31'b0, i_op1 < i_op2};
      ALU_SLL:  alu_res = i_op1 << shamt;
      ALU_SRL:  alu_res = i_op1 >> shamt;
      ALU_SRA:  alu_res = $unsigned($signed(i_op1) >>> shamt);
      default:  alu_res = '0;
    endcase
  end

  assign pc_select_d = i_inst_jal_jalr | (i_inst_branch & branch_cond(i_funct3, i_op1, i_op2));

`ifdef RV_ALU2_DIV_EN
  logic        div_start, div_busy, div_done;
  logic [31:0] div_q, div_r;

  // A divide only starts from IDLE; the instruction is held upstream until DONE loads it.
  assign div_start = i_alu_ctrl.div & ~div_busy & ~div_done & ~i_stall & ~i_flush;

  rv_div u_div (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_abort     (i_flush),
    .i_start     (div_start),
    .i_hold      (i_stall),
    .i_signed    (~i_funct3[0]),
    .i_dividend  (i_op1),
    .i_divisor   (i_op2),
    .o_busy      (div_busy),
    .o_done      (div_done),
    .o_quotient  (div_q),
    .o_remainder (div_r)
  );

  assign o_stall_req = div_start | div_busy;
  assign result_d    = i_alu_ctrl.div ? (i_funct3[1] ? div_r : div_q) : alu_res;
  assign reg_write_d = i_reg_write;
  assign to_trap_d   = i_to_trap;
`else
  // No divider: a divide op is killed as an illegal instruction.
  assign o_stall_req = 1'b0;
  assign result_d    = i_alu_ctrl.div ? 32'd0 : alu_res;
  assign reg_write_d = i_reg_write & ~i_alu_ctrl.div;
  assign to_trap_d   = i_to_trap | i_alu_ctrl.div;
`endif

  assign load = ~i_stall & ~o_stall_req;

  // Pipeline register toward the memory stage; flush clears only the control fields.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pc_select  <= 1'b0;
      o_pc_target  <= '0;
      o_result     <= '0;
      o_store_data <= '0;
      o_rd         <= '0;
      o_reg_write  <= 1'b0;
      o_store      <= 1'b0;
      o_res_src    <= RES_ALU;
      o_funct3     <= '0;
      o_pc_next    <= '0;
      o_to_trap    <= 1'b0;
    end else if (i_flush) begin
      o_reg_write  <= 1'b0;
      o_store      <= 1'b0;
      o_pc_select  <= 1'b0;
      o_to_trap    <= 1'b0;
      o_rd         <= '0;
    end else if (load) begin
      o_pc_select  <= pc_select_d;
      o_pc_target  <= i_pc_target;
      o_result     <= result_d;
      o_store_data <= i_store_data;
      o_rd         <= i_rd;
      o_reg_write  <= reg_write_d;
      o_store      <= i_store;
      o_res_src    <= i_res_src;
      o_funct3     <= i_funct3;
      o_pc_next    <= i_pc_next;
      o_to_trap    <= to_trap_d;
    end
  end

endmodule

// File: tb/tb_rv_alu2.sv
// Directed bench for rv_alu2: table of ALU/branch vectors, then hand-written
// stall, flush and divider sequences (divider set follows RV_ALU2_DIV_EN).
module tb_rv_alu2;
  import rv_structs::*;

  localparam int IAB = 16;

  logic              i_clk = 1'b0;
  logic              i_reset, i_flush, i_stall;
  logic [31:0]       i_op1, i_op2, i_store_data;
  logic [2:0]        i_funct3;
  alu_ctrl_t         i_alu_ctrl;
  logic [4:0]        i_rd;
  logic              i_reg_write, i_store, i_inst_jal_jalr, i_inst_branch, i_to_trap;
  res_src_t          i_res_src;
  logic [IAB-1:1]    i_pc_next, i_pc_target;
  logic              o_stall_req, o_pc_select;
  logic [IAB-1:1]    o_pc_target, o_pc_next;
  logic [31:0]       o_result, o_store_data;
  logic [4:0]        o_rd;
  logic              o_reg_write, o_store, o_to_trap;
  res_src_t          o_res_src;
  logic [2:0]        o_funct3;

  always #5 i_clk = ~i_clk;

  rv_alu2 #(.IADDR_SPACE_BITS(IAB)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush), .i_stall(i_stall),
    .i_op1(i_op1), .i_op2(i_op2), .i_store_data(i_store_data),
    .i_funct3(i_funct3), .i_alu_ctrl(i_alu_ctrl), .i_rd(i_rd),
    .i_reg_write(i_reg_write), .i_store(i_store),
    .i_inst_jal_jalr(i_inst_jal_jalr), .i_inst_branch(i_inst_branch),
    .i_to_trap(i_to_trap), .i_res_src(i_res_src),
    .i_pc_next(i_pc_next), .i_pc_target(i_pc_target),
    .o_stall_req(o_stall_req), .o_pc_select(o_pc_select),
    .o_pc_target(o_pc_target), .o_result(o_result),
    .o_store_data(o_store_data), .o_rd(o_rd), .o_reg_write(o_reg_write),
    .o_store(o_store), .o_res_src(o_res_src), .o_funct3(o_funct3),
    .o_pc_next(o_pc_next), .o_to_trap(o_to_trap)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  task automatic set_nop();
    i_flush = 1'b0; i_stall = 1'b0;
    i_op1 = '0; i_op2 = '0; i_store_data = '0; i_funct3 = '0;
    i_alu_ctrl.div = 1'b0; i_alu_ctrl.op = ALU_ADD;
    i_rd = '0; i_reg_write = 1'b0; i_store = 1'b0;
    i_inst_jal_jalr = 1'b0; i_inst_branch = 1'b0; i_to_trap = 1'b0;
    i_res_src = RES_ALU; i_pc_next = '0; i_pc_target = '0;
  endtask

  task automatic drive(input alu_op_e op, input logic dv, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic jal, input logic [4:0] rd);
    i_alu_ctrl.div = dv; i_alu_ctrl.op = op; i_funct3 = f3;
    i_op1 = a; i_op2 = b; i_inst_branch = br; i_inst_jal_jalr = jal;
    i_rd = rd; i_reg_write = 1'b1;
  endtask

  typedef struct {
    alu_op_e     op;
    logic [2:0]  f3;
    logic [31:0] a, b;
    logic        br, jal;
    logic [31:0] exp_res;
    logic        exp_sel;
  } vec_t;

  localparam int NV = 19;
  vec_t vecs[NV];

`ifdef RV_ALU2_DIV_EN
  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a, b, exp_res;
  } dvec_t;
  localparam int ND = 12;
  dvec_t dvecs[ND];

  task automatic run_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold_done);
    int n;
    logic [31:0] prev;
    @(negedge i_clk);
    prev = o_result;
    drive(ALU_ADD, 1'b1, f3, a, b, 1'b0, 1'b0, 5'd7);
    #1;
    n = 0;
    while (o_stall_req === 1'b1 && n < 60) begin
      n++;
      @(negedge i_clk);
      #1;
    end
    chk("div_stall_cycles", 32'(n), 32'd33);
    if (hold_done > 0) begin
      i_stall = 1'b1;
      repeat (hold_done) begin
        @(negedge i_clk);
        #1;
        chk1("div_hold_stall_req", o_stall_req, 1'b0);
        chk("div_hold_result", o_result, prev);
      end
      i_stall = 1'b0;
    end
    @(negedge i_clk);
    #1;
    chk("div_result", o_result, exp);
    chk1("div_reg_write", o_reg_write, 1'b1);
    set_nop();
  endtask
`endif

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0]  = '{ALU_ADD,  3'b000, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0};
    vecs[1]  = '{ALU_SUB,  3'b000, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0};
    vecs[2]  = '{ALU_AND,  3'b000, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 1'b0, 1'b0, 32'h00F0_00F0, 1'b0};
    vecs[3]  = '{ALU_OR,   3'b000, 32'h1234_0000, 32'h0000_5678, 1'b0, 1'b0, 32'h1234_5678, 1'b0};
    vecs[4]  = '{ALU_XOR,  3'b000, 32'hFFFF_0000, 32'h0F0F_0F0F, 1'b0, 1'b0, 32'hF0F0_0F0F, 1'b0};
    vecs[5]  = '{ALU_SLT,  3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0001, 1'b0};
    vecs[6]  = '{ALU_SLTU, 3'b000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b0};
    vecs[7]  = '{ALU_SLL,  3'b000, 32'h0000_0001, 32'h0000_0021, 1'b0, 1'b0, 32'h0000_0002, 1'b0};
    vecs[8]  = '{ALU_SRL,  3'b000, 32'h8000_0000, 32'h0000_001F, 1'b0, 1'b0, 32'h0000_0001, 1'b0};
    vecs[9]  = '{ALU_SRA,  3'b000, 32'h8000_0000, 32'h0000_0004, 1'b0, 1'b0, 32'hF800_0000, 1'b0};
    vecs[10] = '{ALU_ADD,  3'b100, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[11] = '{ALU_ADD,  3'b110, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    vecs[12] = '{ALU_ADD,  3'b000, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_000A, 1'b1};
    vecs[13] = '{ALU_ADD,  3'b101, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b0};
    vecs[14] = '{ALU_ADD,  3'b010, 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b0, 32'h0000_000A, 1'b0};
    vecs[15] = '{ALU_ADD,  3'b000, 32'h0000_0001, 32'h0000_0002, 1'b0, 1'b1, 32'h0000_0003, 1'b1};
    vecs[16] = '{ALU_ADD,  3'b001, 32'h0000_0005, 32'h0000_0006, 1'b1, 1'b0, 32'h0000_000B, 1'b1};
    vecs[17] = '{ALU_ADD,  3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 1'b0, 32'h0000_0000, 1'b1};
    vecs[18] = '{ALU_SLT,  3'b000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'h0000_0000, 1'b0};

`ifdef RV_ALU2_DIV_EN
    dvecs[0]  = '{F3_DIV,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD};
    dvecs[1]  = '{F3_REM,  32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF};
    dvecs[2]  = '{F3_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF};
    dvecs[3]  = '{F3_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005};
    dvecs[4]  = '{F3_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    dvecs[5]  = '{F3_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    dvecs[6]  = '{F3_DIVU, 32'h0000_0064, 32'h0000_0007, 32'h0000_000E};
    dvecs[7]  = '{F3_REMU, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002};
    dvecs[8]  = '{F3_DIV,  32'h0000_0007, 32'hFFFF_FFFE, 32'hFFFF_FFFD};
    dvecs[9]  = '{F3_REM,  32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001};
    dvecs[10] = '{F3_DIV,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFFF};
    dvecs[11] = '{F3_REM,  32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9};
`endif

    // Reset with busy-looking inputs: every output must read zero.
    set_nop();
    i_reset = 1'b1;
    drive(ALU_OR, 1'b0, 3'b000, 32'h1234_5678, 32'h0F0F_0F0F, 1'b0, 1'b1, 5'd9);
    i_store = 1'b1; i_to_trap = 1'b1; i_store_data = 32'hDEAD_BEEF;
    repeat (3) @(negedge i_clk);
    #1;
    chk("rst_result", o_result, 32'd0);
    chk("rst_store_data", o_store_data, 32'd0);
    chk("rst_ctrl", {27'd0, o_reg_write, o_store, o_pc_select, o_to_trap, o_stall_req}, 32'd0);
    chk("rst_rd", 32'(o_rd), 32'd0);
    chk("rst_pc_target", 32'(o_pc_target), 32'd0);
    i_reset = 1'b0;
    set_nop();

    for (int i = 0; i < NV; i++) begin
      @(negedge i_clk);
      drive(vecs[i].op, 1'b0, vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].br, vecs[i].jal, 5'(i + 1));
      i_pc_target  = (IAB-1)'(i * 6 + 64);
      i_store_data = 32'hA500_0000 + 32'(i);
      @(posedge i_clk);
      #1;
      chk($sformatf("vec%0d_result", i), o_result, vecs[i].exp_res);
      chk1($sformatf("vec%0d_pc_select", i), o_pc_select, vecs[i].exp_sel);
      chk($sformatf("vec%0d_pc_target", i), 32'(o_pc_target), 32'(i * 6 + 64));
      chk($sformatf("vec%0d_rd", i), 32'(o_rd), 32'(i + 1));
      chk($sformatf("vec%0d_funct3", i), 32'(o_funct3), 32'(vecs[i].f3));
      chk($sformatf("vec%0d_store_data", i), o_store_data, 32'hA500_0000 + 32'(i));
    end

    // Downstream stall: outputs must freeze while a different instruction waits.
    @(negedge i_clk);
    drive(ALU_ADD, 1'b0, 3'b000, 32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 5'd4);
    @(posedge i_clk);
    #1;
    chk("stall_pre_result", o_result, 32'h8000_0000);
    @(negedge i_clk);
    i_stall = 1'b1;
    drive(ALU_SUB, 1'b0, 3'b000, 32'h0, 32'h1, 1'b0, 1'b1, 5'd9);
    repeat (2) begin
      @(posedge i_clk);
      #1;
      chk("stall_hold_result", o_result, 32'h8000_0000);
      chk1("stall_hold_pc_select", o_pc_select, 1'b0);
      chk("stall_hold_rd", 32'(o_rd), 32'd4);
    end
    @(negedge i_clk);
    i_stall = 1'b0;
    @(posedge i_clk);
    #1;
    chk("stall_release_result", o_result, 32'hFFFF_FFFF);
    chk1("stall_release_pc_select", o_pc_select, 1'b1);

    // Flush kills the control fields of the instruction in stage.
    @(negedge i_clk);
    drive(ALU_ADD, 1'b0, 3'b000, 32'h3, 32'h4, 1'b0, 1'b1, 5'd12);
    i_flush = 1'b1;
    @(posedge i_clk);
    #1;
    chk1("flush_reg_write", o_reg_write, 1'b0);
    chk1("flush_pc_select", o_pc_select, 1'b0);
    chk("flush_rd", 32'(o_rd), 32'd0);
    @(negedge i_clk);
    set_nop();

`ifdef RV_ALU2_DIV_EN
    for (int i = 0; i < ND; i++)
      run_div(dvecs[i].f3, dvecs[i].a, dvecs[i].b, dvecs[i].exp_res, (i == 1) ? 3 : 0);

    // Flush in the tenth RUN cycle aborts the divide; the next ADD is unaffected.
    @(negedge i_clk);
    drive(ALU_ADD, 1'b1, F3_DIVU, 32'd100, 32'd7, 1'b0, 1'b0, 5'd7);
    repeat (10) @(negedge i_clk);
    #1;
    chk1("divflush_busy", o_stall_req, 1'b1);
    set_nop();
    i_flush = 1'b1;
    @(negedge i_clk);
    i_flush = 1'b0;
    #1;
    chk1("divflush_stall_req", o_stall_req, 1'b0);
    chk1("divflush_reg_write", o_reg_write, 1'b0);
    drive(ALU_ADD, 1'b0, 3'b000, 32'd3, 32'd4, 1'b0, 1'b0, 5'd3);
    @(posedge i_clk);
    #1;
    chk("divflush_next_result", o_result, 32'd7);
    chk1("divflush_next_reg_write", o_reg_write, 1'b1);
    chk1("divflush_next_stall_req", o_stall_req, 1'b0);
    @(negedge i_clk);
    set_nop();
`else
    // No divider: a divide is an illegal instruction retired in one cycle.
    @(negedge i_clk);
    drive(ALU_ADD, 1'b1, F3_DIV, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 5'd7);
    #1;
    chk1("nodiv_stall_req", o_stall_req, 1'b0);
    @(posedge i_clk);
    #1;
    chk("nodiv_result", o_result, 32'd0);
    chk1("nodiv_reg_write", o_reg_write, 1'b0);
    chk1("nodiv_to_trap", o_to_trap, 1'b1);
    chk1("nodiv_stall_req_after", o_stall_req, 1'b0);
    @(negedge i_clk);
    set_nop();
    @(posedge i_clk);
    #1;
    chk1("nodiv_trap_clears", o_to_trap, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
